// File: rtl/uart_alu_ctrl.sv
// UART command controller: gathers operand A, operand B and an opcode from the RX FIFO,
// runs the built-in ALU and streams the result to the TX FIFO. Optional status byte: ALU_STATUS_BYTE_EN.
module uart_alu_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx_empty,
  input  logic [7:0] i_r_data,
  output logic       o_rd_uart,
  input  logic       i_tx_full,
  output logic [7:0] o_w_data,
  output logic       o_wr_uart,
  output logic       o_busy,
  output logic       o_err_timeout
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRL = 6'h02;
  localparam logic [5:0] OP_SRA = 6'h03;

  typedef enum logic [2:0] {
    S_RX_A,
    S_RX_B,
    S_RX_OP,
    S_EXEC,
    S_TX
`ifdef ALU_STATUS_BYTE_EN
    , S_STATUS
`endif
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [TO_W-1:0]     r_to_cnt, w_to_nxt;
  logic                r_err, w_err_nxt;
  logic [DATA_W-1:0]   r_a, r_b, r_result;
  logic [5:0]          r_op;

  logic                w_rx_st, w_pop, w_push, w_busy;
  logic                w_last_byte;
  logic [DATA_W-1:0]   w_sum, w_diff, w_alu;
  logic                w_big;

  // Handshakes are qualified by reset so nothing moves while the block is held in reset.
  assign w_rx_st     = (r_state == S_RX_A) || (r_state == S_RX_B) || (r_state == S_RX_OP);
  assign w_pop       = i_reset && w_rx_st && !i_rx_empty;
`ifdef ALU_STATUS_BYTE_EN
  assign w_push      = i_reset && ((r_state == S_TX) || (r_state == S_STATUS)) && !i_tx_full;
`else
  assign w_push      = i_reset && (r_state == S_TX) && !i_tx_full;
`endif
  assign w_busy      = (r_state != S_RX_A) || (r_cnt != '0);
  assign w_last_byte = (r_cnt == CNT_W'(NBYTES - 1));

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_RX_A;
      r_cnt    <= '0;
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_to_cnt <= w_to_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next-state, shared byte counter and inter-byte timeout
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = '0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_RX_A: begin
        if (w_pop) begin
          if (w_last_byte) begin
            w_state_nxt = S_RX_B;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_RX_B: begin
        if (w_pop) begin
          if (w_last_byte) begin
            w_state_nxt = S_RX_OP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_RX_OP: begin
        if (w_pop) begin
          w_state_nxt = S_EXEC;
          w_cnt_nxt   = '0;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_TX;
        w_cnt_nxt   = '0;
      end
      S_TX: begin
        if (w_push) begin
          if (w_last_byte) begin
`ifdef ALU_STATUS_BYTE_EN
            w_state_nxt = S_STATUS;
`else
            w_state_nxt = S_RX_A;
`endif
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
`ifdef ALU_STATUS_BYTE_EN
      S_STATUS: begin
        if (w_push) begin
          w_state_nxt = S_RX_A;
          w_cnt_nxt   = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = S_RX_A;
        w_cnt_nxt   = '0;
      end
    endcase
    // A pop always clears the idle count, so a pop on the expiry cycle keeps the frame alive.
    if (w_rx_st && w_busy && !w_pop) begin
      if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
        w_state_nxt = S_RX_A;
        w_cnt_nxt   = '0;
        w_err_nxt   = 1'b1;
      end else begin
        w_to_nxt = r_to_cnt + TO_W'(1);
      end
    end
  end

`ifdef ALU_STATUS_BYTE_EN
  logic       w_carry_add, w_borrow, w_carry, w_ovf, w_invalid;
  logic [7:0] r_status;

  assign {w_carry_add, w_sum} = {1'b0, r_a} + {1'b0, r_b};
  assign {w_borrow, w_diff}   = {1'b0, r_a} - {1'b0, r_b};
  assign w_carry   = (r_op == OP_ADD) ? w_carry_add : ((r_op == OP_SUB) ? w_borrow : 1'b0);
  assign w_invalid = !(r_op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRL, OP_SRA});

  // Signed overflow: same-sign inputs to ADD (or opposite-sign to SUB) yielding a sign flip.
  always_comb begin
    w_ovf = 1'b0;
    if (r_op == OP_ADD)
      w_ovf = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
    else if (r_op == OP_SUB)
      w_ovf = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_diff[DATA_W-1] != r_a[DATA_W-1]);
  end
`else
  assign w_sum  = r_a + r_b;
  assign w_diff = r_a - r_b;
`endif

  assign w_big = (r_b >= DATA_W'(DATA_W));

  // ALU result; unknown opcodes produce zero
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = w_sum;
      OP_SUB:  w_alu = w_diff;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_NOR:  w_alu = ~(r_a | r_b);
      OP_SRL:  w_alu = w_big ? '0 : (r_a >> r_b);
      OP_SRA:  w_alu = w_big ? {DATA_W{r_a[DATA_W-1]}} : DATA_W'($signed(r_a) >>> r_b);
      default: w_alu = '0;
    endcase
  end

  // Operands shift in from the top so the first (least significant) byte lands at the bottom.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
`ifdef ALU_STATUS_BYTE_EN
      r_status <= '0;
`endif
    end else begin
      if (w_pop && (r_state == S_RX_A))
        r_a <= DATA_W'({i_r_data, r_a} >> 8);
      if (w_pop && (r_state == S_RX_B))
        r_b <= DATA_W'({i_r_data, r_b} >> 8);
      if (w_pop && (r_state == S_RX_OP))
        r_op <= i_r_data[5:0];
      if (r_state == S_EXEC) begin
        r_result <= w_alu;
`ifdef ALU_STATUS_BYTE_EN
        r_status <= {3'b000, w_invalid, w_ovf, w_alu[DATA_W-1], w_carry, (w_alu == '0)};
`endif
      end else if (w_push && (r_state == S_TX)) begin
        r_result <= DATA_W'({8'h00, r_result} >> 8);
      end
    end
  end

  // Current TX byte; held steady while the TX FIFO is full
  always_comb begin
    o_w_data = 8'h00;
    case (r_state)
      S_TX:     o_w_data = r_result[7:0];
`ifdef ALU_STATUS_BYTE_EN
      S_STATUS: o_w_data = r_status;
`endif
      default:  o_w_data = 8'h00;
    endcase
  end

  assign o_rd_uart     = w_pop;
  assign o_wr_uart     = w_push;
  assign o_busy        = w_busy;
  assign o_err_timeout = r_err;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: 8-bit and 16-bit instances fed from modelled RX/TX FIFOs.
module tb_uart_alu_ctrl;

  localparam int unsigned TO = 40;
`ifdef ALU_STATUS_BYTE_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       empty8 = 1'b1, full8 = 1'b0, empty16 = 1'b1, full16 = 1'b0;
  logic [7:0] rdata8 = 8'h00, rdata16 = 8'h00;
  logic       rd8, wr8, busy8, err8, rd16, wr16, busy16, err16;
  logic [7:0] wdata8, wdata16;

  bq_t rxq8, txq8, rxq16, txq16;
  int  n_chk = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  uart_alu_ctrl #(.DATA_W(8), .TIMEOUT(TO)) u_dut8 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_empty(empty8), .i_r_data(rdata8),
    .o_rd_uart(rd8), .i_tx_full(full8), .o_w_data(wdata8), .o_wr_uart(wr8),
    .o_busy(busy8), .o_err_timeout(err8)
  );

  uart_alu_ctrl #(.DATA_W(16), .TIMEOUT(TO)) u_dut16 (
    .i_clk(clk), .i_reset(rst_n), .i_rx_empty(empty16), .i_r_data(rdata16),
    .o_rd_uart(rd16), .i_tx_full(full16), .o_w_data(wdata16), .o_wr_uart(wr16),
    .o_busy(busy16), .o_err_timeout(err16)
  );

  // FIFO models: head presented on the falling edge, pops/pushes taken on the rising edge.
  always @(negedge clk) begin
    empty8  = (rxq8.size() == 0);
    rdata8  = (rxq8.size() != 0) ? rxq8[0] : 8'h00;
    empty16 = (rxq16.size() == 0);
    rdata16 = (rxq16.size() != 0) ? rxq16[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (rd8 && rxq8.size() != 0) void'(rxq8.pop_front());
    if (wr8) txq8.push_back(wdata8);
    if (rd16 && rxq16.size() != 0) void'(rxq16.pop_front());
    if (wr16) txq16.push_back(wdata16);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input int which, input bq_t b);
    foreach (b[i]) begin
      if (which == 8) rxq8.push_back(b[i]);
      else            rxq16.push_back(b[i]);
    end
  endtask

  task automatic add_exp(inout bq_t e, input bq_t res, input logic [7:0] st);
    foreach (res[i]) e.push_back(res[i]);
    if (STATUS_EN) e.push_back(st);
  endtask

  task automatic wait_idle(input int which, input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (((which == 8) ? (rxq8.size() != 0 || busy8) : (rxq16.size() != 0 || busy16)) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < 1000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_tx(input int which, input string tag, input bq_t exp);
    bq_t got;
    if (which == 8) begin got = txq8;  txq8.delete();  end
    else            begin got = txq16; txq16.delete(); end
    check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
  endtask

  task automatic run8(input string tag, input bq_t frame, input logic [7:0] res, input logic [7:0] st);
    bq_t e;
    send(8, frame);
    wait_idle(8, tag);
    add_exp(e, '{res}, st);
    check_tx(8, tag, e);
    check({tag, "_busy"}, 32'(busy8), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bq_t e;
    int  n_err;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd",    32'(rd8),    32'd0);
    check("rst_wr",    32'(wr8),    32'd0);
    check("rst_wdata", 32'(wdata8), 32'd0);
    check("rst_busy",  32'(busy8),  32'd0);
    check("rst_err",   32'(err8),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8-bit directed frames
    run8("add",  '{8'h80, 8'h80, 8'h20}, 8'h00, 8'h0B);
    run8("sra",  '{8'h80, 8'h03, 8'h03}, 8'hF0, 8'h04);
    run8("srl",  '{8'h80, 8'h03, 8'h02}, 8'h10, 8'h00);
    run8("sra9", '{8'h80, 8'h09, 8'h03}, 8'hFF, 8'h04);
    run8("srl9", '{8'h80, 8'h09, 8'h02}, 8'h00, 8'h01);
    run8("inv",  '{8'h12, 8'h34, 8'h3F}, 8'h00, 8'h11);
    run8("nor",  '{8'h0F, 8'h30, 8'h27}, 8'hC0, 8'h04);

    // Truncated frame: one A byte then silence
    send(8, '{8'h11, 8'h00});
    void'(rxq8.pop_back());
    n_err = 0;
    repeat (TO / 2) begin @(negedge clk); if (err8) n_err++; end
    check("to_busy_mid", 32'(busy8), 32'd1);
    repeat (TO) begin @(negedge clk); if (err8) n_err++; end
    check("to_pulses", 32'(n_err), 32'd1);
    check("to_busy", 32'(busy8), 32'd0);
    check("to_nopush", 32'(txq8.size()), 32'd0);
    run8("sub", '{8'h05, 8'h03, 8'h22}, 8'h02, 8'h00);

    // 16-bit: two frames queued together; the second waits in the FIFO during EXEC/TX
    send(16, '{8'h34, 8'h12, 8'h0F, 8'h0F, 8'h24, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h20});
    wait_idle(16, "w16");
    e.delete();
    add_exp(e, '{8'h04, 8'h02}, 8'h00);
    add_exp(e, '{8'h00, 8'h00}, 8'h03);
    check_tx(16, "w16", e);

    // Backpressure on the 16-bit instance
    full16 = 1'b1;
    send(16, '{8'hCD, 8'hAB, 8'h11, 8'h11, 8'h25});
    repeat (100) @(negedge clk);
    check("bp_nopush", 32'(txq16.size()), 32'd0);
    check("bp_busy",   32'(busy16), 32'd1);
    check("bp_wdata",  32'(wdata16), 32'hDD);
    full16 = 1'b0;
    wait_idle(16, "bp");
    e.delete();
    add_exp(e, '{8'hDD, 8'hBB}, 8'h04);
    check_tx(16, "bp", e);

    // Reset while the 8-bit instance is stalled in TX
    full8 = 1'b1;
    send(8, '{8'h07, 8'h05, 8'h26});
    repeat (10) @(negedge clk);
    check("mrst_busy_pre",  32'(busy8),  32'd1);
    check("mrst_wdata_pre", 32'(wdata8), 32'h02);
    rst_n = 1'b0;
    full8 = 1'b0;
    #1;
    check("mrst_rd",    32'(rd8),    32'd0);
    check("mrst_wr",    32'(wr8),    32'd0);
    check("mrst_wdata", 32'(wdata8), 32'd0);
    check("mrst_busy",  32'(busy8),  32'd0);
    check("mrst_err",   32'(err8),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mrst_nopush", 32'(txq8.size()), 32'd0);
    check("mrst_busy",   32'(busy8), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Parametrised command controller between the UART RX/TX FIFOs and a built-in ALU of DATA_W bits. It assembles multi-byte operands A and B plus an opcode byte from the RX FIFO, executes the operation, and streams the result back through the TX FIFO. An optional status byte follows the result. An inter-byte timeout recovers from truncated frames.

## Interface
- DATA_W, 8, operand/result width; multiple of 8, range 8..32; NBYTES = DATA_W/8
- TIMEOUT, 1000000, idle clocks allowed between bytes of one frame (20 ms at 50 MHz)
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_rx_empty  in  1  RX FIFO empty
- i_r_data  in  8  RX FIFO head word (first-word-fall-through)
- o_rd_uart  out  1  RX FIFO pop strobe
- i_tx_full  in  1  TX FIFO full
- o_w_data  out  8  byte to TX FIFO
- o_wr_uart  out  1  TX FIFO push strobe
- o_busy  out  1  frame in progress
- o_err_timeout  out  1  one-cycle pulse on frame abort

## Operation
- Frame is A (NBYTES, LSB first), then B (NBYTES, LSB first), then opcode byte (bits 5:0 used).
- Opcodes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRL 0x02, SRA 0x03.
- Any other opcode gives result 0 and sets the invalid flag.
- FSM states:
  - RX_A → RX_B after NBYTES pops.
  - RX_B → RX_OP after NBYTES pops.
  - RX_OP → EXEC on pop.
  - EXEC → TX (one cycle; result and flags registered).
  - TX → RX_A after last byte (or STATUS when enabled).
- Byte counter shared by RX_A, RX_B and TX; cleared on each state change.
- Receive states: o_rd_uart = !i_rx_empty (combinational from state); i_r_data is captured on the same edge. Back-to-back pops allowed.
- TX state: o_wr_uart = !i_tx_full; o_w_data = result byte[counter], LSB first.
- Arithmetic is modulo 2^DATA_W.
  - Carry = ADD carry-out, or SUB borrow (A < B unsigned).
  - Overflow = signed overflow of ADD/SUB; 0 otherwise.
- Shifts: amount = B (unsigned). For B ≥ DATA_W, SRL gives 0 and SRA gives all bits equal to A[DATA_W-1].
- Timeout counter:
  - Cleared on every pop; counts while o_busy=1 and no pop occurs.
  - Reaching TIMEOUT discards the partial frame, returns to RX_A and pulses o_err_timeout.
  - Not active in EXEC/TX.
- o_busy = 1 from the first pop of A until the edge of the last TX push.

## Timing
- Reset (i_reset=0): state RX_A, counters 0, o_rd_uart=0, o_wr_uart=0, o_w_data=0x00, o_busy=0, o_err_timeout=0. Reset mid-frame or mid-TX drops everything; no partial bytes are pushed afterwards.
- Latency: opcode pop at edge N; EXEC registers at edge N+1; first o_wr_uart is high in the cycle after N+1 if !i_tx_full.
- Backpressure: while i_tx_full=1, o_wr_uart=0 and o_w_data holds the current byte; no byte is lost or repeated.
- RX bytes arriving during EXEC/TX stay in the FIFO (no pop) and start the next frame afterwards.
- Timeout and pop in the same cycle: pop wins and the counter clears.

## Configuration
- ALU_STATUS_BYTE_EN defined:
  - After the last result byte, state STATUS pushes one byte: bit0 zero, bit1 carry, bit2 negative (result MSB), bit3 overflow, bit4 invalid opcode, bits 7:5 = 0.
  - TX length = NBYTES+1.
- ALU_STATUS_BYTE_EN undefined: no STATUS state and no flag logic; TX length = NBYTES.

## Test plan
- DATA_W=8, ALU_STATUS_BYTE_EN, RX 0x80,0x80,0x20 → TX 0x00 then status 0x0B; o_busy drops after second push.
- DATA_W=16, RX 0x34,0x12,0x0F,0x0F,0x24 → TX 0x04,0x02 (0x0204), status 0x00.
- DATA_W=8, RX 0x80,0x03,0x03 (SRA) → 0xF0, status 0x04; repeat with opcode 0x02 (SRL) → 0x10; B=0x09 with SRA → 0xFF.
- DATA_W=8, opcode 0x3F → result 0x00, status 0x11.
- Send A byte only, idle TIMEOUT clocks → single o_err_timeout pulse, o_busy=0. Next full frame 0x05,0x03,0x22 → 0x02.
- Hold i_tx_full=1 across EXEC for 100 cycles → no o_wr_uart; release → result bytes pushed in order exactly once. Assert i_reset=0 mid-TX → all outputs zero, no further pushes.
